fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage: PC register, instruction-memory request/ack handshake, and the IF/ID pipeline latch, all in one block.
- Sits directly upstream of the decode stage. Consumes the load-use hazard controls (stall to IF/ID, PC write enable) and the taken-branch flush/redirect from ID.
- Tolerates variable-latency instruction memory. Holds fetched data in a one-entry buffer while ID is stalled.

Parameters:
- PC_WIDTH, 32, width of PC, memory address and IF/ID PC field.
- RESET_PC, 0, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, encoding driven on instr_o for bubbles.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  begin fetching; sampled only in IDLE.
- Stall_i  in  1  hazard unit: hold IF/ID latch.
- PCWrite_i  in  1  hazard unit: 1 = PC may advance.
- Flush_i  in  1  taken branch in ID: squash fetch, redirect.
- BranchTarget_i  in  PC_WIDTH  redirect address, valid with Flush_i.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  PC_WIDTH  fetch address.
- imem_ack_i  in  1  data valid this cycle; only meaningful while imem_req_o=1.
- imem_data_i  in  32  fetched instruction.
- pc_o  out  PC_WIDTH  IF/ID latched PC.
- instr_o  out  32  IF/ID latched instruction.
- valid_o  out  1  IF/ID entry holds a real instruction.

Behaviour:
- Reset (rst_i=0, asynchronous): state=IDLE, pc=RESET_PC, imem_req_o=0, imem_addr_o=RESET_PC, pc_o=0, instr_o=NOP_INSTR, valid_o=0, buffer empty, redirect_pending=0.
  - Reset mid-request abandons the request. Memory must tolerate a dropped request.
- Definitions:
  - hold = Stall_i | ~PCWrite_i.
  - bubble = IF/ID loads pc_o=pc, instr_o=NOP_INSTR, valid_o=0.
- IDLE: imem_req_o=0. Go to FETCH at the edge where start_i=1. start_i is ignored in all other states.
- FETCH:
  - Combinationally, imem_req_o=1 and imem_addr_o=pc.
  - Address stays stable until the ack. A request is never withdrawn except by reset.
  - Edge with ack=1, no flush, redirect_pending=0:
    - hold=0: IF/ID <= {pc, imem_data_i, valid=1}; pc <= pc+4 (mod 2^PC_WIDTH); stay in FETCH. Back-to-back requests are allowed, so throughput is 1 instruction per cycle with a zero-wait memory.
    - hold=1: buffer <= {pc, imem_data_i}; IF/ID unchanged; go to HOLD.
  - Edge with ack=0, no flush: if hold=0, load a bubble; if hold=1, IF/ID unchanged.
- HOLD:
  - imem_req_o=0 and the IF/ID latch is unchanged.
  - Edge with hold=0: IF/ID <= {buffer, valid=1}; pc <= buffer pc+4; go to FETCH.
- Flush_i=1 (any state except IDLE) overrides hold:
  - IF/ID always loads a bubble.
  - FETCH with ack=1: discard imem_data_i; pc <= BranchTarget_i; stay in FETCH.
  - FETCH with ack=0: redirect_pending <= 1; redirect_pc <= BranchTarget_i. The request continues at the old address.
  - HOLD: drop the buffer; pc <= BranchTarget_i; go to FETCH.
- redirect_pending=1 in FETCH:
  - The ack edge discards data, sets pc <= redirect_pc, and clears the flag. IF/ID loads a bubble unless hold=1.
  - A new flush while pending overwrites redirect_pc. A flush on the ack edge uses BranchTarget_i directly.
- Flush in IDLE is ignored.
- PC low two bits are carried unchanged. No alignment check.

Test Plan:
- Reset with RESET_PC=0, start_i pulse, zero-wait memory (ack same cycle) -> imem_addr_o = 0, 4, 8 on consecutive cycles; pc_o/instr_o follow one cycle later with valid_o=1.
- Memory with 2 wait cycles -> imem_addr_o stays 0x10 for 3 cycles; IF/ID shows bubbles (valid_o=0, instr_o=0x00000013) until ack, then {0x10, data}.
- Stall_i=1, PCWrite_i=0 asserted on the ack cycle for address 0x20 -> IF/ID holds the old entry, imem_req_o=0 for 2 stall cycles; on release IF/ID={0x20, data}, next address 0x24.
- Flush_i=1 with BranchTarget_i=0x100 on a zero-wait ack at 0x30 -> IF/ID bubble, next imem_addr_o=0x100, data for 0x30 never appears on instr_o.
- Flush to 0x200 during the first wait cycle, then flush to 0x300 before the ack -> request at the old address completes and is discarded; next imem_addr_o=0x300.
- rst_i driven low mid-request -> outputs return to reset values immediately, without a clock edge.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ack bus between the fetch stage (master) and the memory (slave).
interface fetch_unit_if #(
  parameter int PC_WIDTH = 32
);
  logic                req;
  logic [PC_WIDTH-1:0] addr;
  logic                ack;
  logic [31:0]         data;

  modport master (output req, addr, input ack, data);
  modport slave  (input req, addr, output ack, data);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, imem request/ack handshake, one-entry stall buffer
// and the IF/ID pipeline latch.
module fetch_unit #(
  parameter int                  PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter logic [31:0]         NOP_INSTR = 32'h00000013
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                Stall_i,
  input  logic                PCWrite_i,
  input  logic                Flush_i,
  input  logic [PC_WIDTH-1:0] BranchTarget_i,
  fetch_unit_if.master        imem,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic [31:0]         instr_o,
  output logic                valid_o
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t              state, stateNext;
  logic [PC_WIDTH-1:0] pc, pcNext;
  logic [PC_WIDTH-1:0] bufPc, bufPcNext;
  logic [31:0]         bufInstr, bufInstrNext;
  logic                redirPending, redirPendingNext;
  logic [PC_WIDTH-1:0] redirPc, redirPcNext;
  logic [PC_WIDTH-1:0] ifPcNext;
  logic [31:0]         ifInstrNext;
  logic                ifValidNext;
  logic                hold, doBubble;

  assign hold      = Stall_i | ~PCWrite_i;
  assign imem.req  = (state == FETCH);
  assign imem.addr = pc;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      bufPc        <= '0;
      bufInstr     <= '0;
      redirPending <= 1'b0;
      redirPc      <= '0;
      pc_o         <= '0;
      instr_o      <= NOP_INSTR;
      valid_o      <= 1'b0;
    end else begin
      state        <= stateNext;
      pc           <= pcNext;
      bufPc        <= bufPcNext;
      bufInstr     <= bufInstrNext;
      redirPending <= redirPendingNext;
      redirPc      <= redirPcNext;
      pc_o         <= ifPcNext;
      instr_o      <= ifInstrNext;
      valid_o      <= ifValidNext;
    end
  end

  always_comb begin
    stateNext        = state;
    pcNext           = pc;
    bufPcNext        = bufPc;
    bufInstrNext     = bufInstr;
    redirPendingNext = redirPending;
    redirPcNext      = redirPc;
    ifPcNext         = pc_o;
    ifInstrNext      = instr_o;
    ifValidNext      = valid_o;
    doBubble         = 1'b0;

    unique case (state)
      IDLE: begin
        if (start_i) stateNext = FETCH;
      end
      FETCH: begin
        if (Flush_i) begin
          doBubble = 1'b1;
          // Flush on the ack edge redirects now; otherwise the request must finish first.
          if (imem.ack) begin
            pcNext           = BranchTarget_i;
            redirPendingNext = 1'b0;
          end else begin
            redirPendingNext = 1'b1;
            redirPcNext      = BranchTarget_i;
          end
        end else if (imem.ack) begin
          if (redirPending) begin
            pcNext           = redirPc;
            redirPendingNext = 1'b0;
            doBubble         = ~hold;
          end else if (!hold) begin
            ifPcNext    = pc;
            ifInstrNext = imem.data;
            ifValidNext = 1'b1;
            pcNext      = pc + PC_WIDTH'(4);
          end else begin
            bufPcNext    = pc;
            bufInstrNext = imem.data;
            stateNext    = HOLD;
          end
        end else begin
          doBubble = ~hold;
        end
      end
      HOLD: begin
        if (Flush_i) begin
          doBubble  = 1'b1;
          pcNext    = BranchTarget_i;
          stateNext = FETCH;
        end else if (!hold) begin
          ifPcNext    = bufPc;
          ifInstrNext = bufInstr;
          ifValidNext = 1'b1;
          pcNext      = bufPc + PC_WIDTH'(4);
          stateNext   = FETCH;
        end
      end
      default: stateNext = IDLE;
    endcase

    if (doBubble) begin
      ifPcNext    = pc;
      ifInstrNext = NOP_INSTR;
      ifValidNext = 1'b0;
    end
  end

endmodule
